// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB types, widths and requester index constants
package cdb_arbiter_pkg;

  localparam int NUM_SRBITS  = 8;
  localparam int CDB_DATA_W  = 32;

  localparam int CDB_NUM_REQ    = 4;
  localparam int CDB_REQ_ALU    = 0;
  localparam int CDB_REQ_MEM    = 1;
  localparam int CDB_REQ_MULDIV = 2;
  localparam int CDB_REQ_BRANCH = 3;

  typedef struct packed {
    logic [NUM_SRBITS-1:0] tag;
    logic [CDB_DATA_W-1:0] val;
  } tagged_data_t;

  typedef struct packed {
    logic                  valid;
    logic [NUM_SRBITS-1:0] tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rtl/cdb_arbiter_rr_pick.sv - combinational round-robin priority encoder
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan ptr, ptr+1, ... wrapping by compare so non-power-of-two N works.
  always_comb begin
    int p;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    p      = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(ptr) + k;
      if (p >= N) p = p - N;
      if (!any && elig[p]) begin
        any       = 1'b1;
        onehot[p] = 1'b1;
        idx       = PW'(p);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic         [NUM_REQ-1:0] req_i,
  input  tagged_data_t [NUM_REQ-1:0] data_i,
  output logic         [NUM_REQ-1:0] grant_o,
  output cdb_bus_t                   cdb_o,
  output logic                       err_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] r_last_gnt;
  cdb_bus_t           r_cdb;
  logic               r_err;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_onehot;
  logic [PW-1:0]      w_idx;
  logic               w_any;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_fire;
  tagged_data_t       w_win;
  logic               w_tag_zero;
  logic [PW-1:0]      w_ptr_next;

  // Last cycle's winner is masked: it only learns of success from cdb_o one cycle later.
  assign w_elig = req_i & ~r_last_gnt;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .elig   (w_elig),
    .ptr    (r_ptr),
    .onehot (w_onehot),
    .idx    (w_idx),
    .any    (w_any)
  );

  assign w_grant    = (rst_n && !flush && w_any) ? w_onehot : '0;
  assign w_fire     = |w_grant;
  assign w_win      = data_i[w_idx];
  assign w_tag_zero = (w_win.tag == '0);
  assign w_ptr_next = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  // Register the winner onto the bus, advance the pointer past it, record the mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb      <= '0;
      r_ptr      <= '0;
      r_last_gnt <= '0;
      r_err      <= 1'b0;
    end else if (w_fire) begin
      r_cdb.valid <= !w_tag_zero;
      r_cdb.tag   <= w_win.tag;
      r_cdb.data  <= w_win.val[DATA_W-1:0];
      r_ptr       <= w_ptr_next;
      r_last_gnt  <= w_grant;
      if (w_tag_zero) r_err <= 1'b1;
    end else begin
      r_cdb.valid <= 1'b0;
      r_last_gnt  <= '0;
    end
  end

  assign grant_o = w_grant;
  assign cdb_o   = r_cdb;
  assign err_o   = r_err;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed-vector self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                     clk;
  logic                     rst_n;
  logic                     flush;
  logic         [3:0]       req;
  tagged_data_t [3:0]       data;
  logic         [3:0]       grant;
  cdb_bus_t                 cdb;
  logic                     err;

  int n_vec;
  int n_bad;

  cdb_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .req_i   (req),
    .data_i  (data),
    .grant_o (grant),
    .cdb_o   (cdb),
    .err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] tags [4];
    logic [3:0] pend;
    n_vec = 0;
    n_bad = 0;
    tags[0] = 8'h21; tags[1] = 8'h41; tags[2] = 8'h61; tags[3] = 8'h81;
    rst_n = 1'b0;
    flush = 1'b0;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      data[i].tag = tags[i];
      data[i].val = 32'h1000_0000 + 32'(i);
    end
    step();
    step();
    expect_eq("rst_cdb_valid", 64'(cdb.valid), 64'd0);
    expect_eq("rst_grant",     64'(grant),     64'd0);
    expect_eq("rst_err",       64'(err),       64'd0);
    rst_n = 1'b1;
    #1;

    // All four requesting, each holds until its tag appears on the bus.
    pend = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      req = pend;
      #1;
      expect_eq($sformatf("rr_grant_%0d", c), 64'(grant), 64'(4'b0001 << c));
      step();
      expect_eq($sformatf("rr_valid_%0d", c), 64'(cdb.valid), 64'd1);
      expect_eq($sformatf("rr_tag_%0d", c),   64'(cdb.tag),   64'(tags[c]));
      for (int i = 0; i < 4; i++) if (cdb.valid && cdb.tag == tags[i]) pend[i] = 1'b0;
    end
    req = pend;
    #1;
    expect_eq("rr_all_retired", 64'(grant), 64'd0);
    step();
    expect_eq("rr_bus_idle", 64'(cdb.valid), 64'd0);

    // Lone BRANCH requester: granted every other cycle.
    data[CDB_REQ_BRANCH].val = 32'h0000_1040;
    req = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      #1;
      expect_eq($sformatf("solo_grant_%0d", k), 64'(grant), (k % 2 == 0) ? 64'h8 : 64'h0);
      step();
      expect_eq($sformatf("solo_valid_%0d", k), 64'(cdb.valid), (k % 2 == 0) ? 64'd1 : 64'd0);
      if (k == 0) expect_eq("solo_data", 64'(cdb.data), 64'h1040);
    end
    req = 4'b0000;

    // Drive ptr to 2 via a lone MEM grant, then req=0011 from ptr 2.
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    req = 4'b0011;
    #1;
    expect_eq("ptr2_first", 64'(grant), 64'h1);
    step();
    #1;
    expect_eq("ptr2_second", 64'(grant), 64'h2);
    step();
    req = 4'b0111;
    #1;
    expect_eq("ptr2_after", 64'(grant), 64'h4);
    req = 4'b0000;
    step();

    // Grant ALU in N, flush in N+1 with everyone requesting.
    req = 4'b0001;
    #1;
    expect_eq("fl_pre_grant", 64'(grant), 64'h1);
    step();
    flush = 1'b1;
    req   = 4'b1111;
    #1;
    expect_eq("fl_grant_zero", 64'(grant),     64'd0);
    expect_eq("fl_bus_valid",  64'(cdb.valid), 64'd1);
    expect_eq("fl_bus_tag",    64'(cdb.tag),   64'h21);
    step();
    expect_eq("fl_bus_cleared", 64'(cdb.valid), 64'd0);
    flush = 1'b0;
    #1;
    expect_eq("fl_ptr_held", 64'(grant), 64'h2);
    req = 4'b0000;
    step();

    // MEM granted with tag 0: grant issued, broadcast suppressed, sticky error.
    data[CDB_REQ_MEM].tag = 8'h00;
    req = 4'b0010;
    #1;
    expect_eq("t0_grant", 64'(grant), 64'h2);
    step();
    req = 4'b0000;
    expect_eq("t0_valid", 64'(cdb.valid), 64'd0);
    expect_eq("t0_err",   64'(err),       64'd1);
    step();
    step();
    expect_eq("t0_err_sticky", 64'(err), 64'd1);

    // Reset asserted while a broadcast is on the bus.
    req = 4'b0001;
    step();
    expect_eq("mid_valid_pre", 64'(cdb.valid), 64'd1);
    req   = 4'b1111;
    rst_n = 1'b0;
    #1;
    expect_eq("mid_rst_valid", 64'(cdb.valid), 64'd0);
    expect_eq("mid_rst_grant", 64'(grant),     64'd0);
    expect_eq("mid_rst_err",   64'(err),       64'd0);
    step();
    rst_n = 1'b1;
    #1;
    expect_eq("mid_rst_ptr0", 64'(grant), 64'h1);
    req = 4'b0000;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
